// File: rtl/uart_pkg.sv
// Purpose : shared UART definitions (default line timing, FSM state encoding, frame layout)
//           for the receiver and the transmitter.
// Ports   : none (package).
package uart_pkg;

   localparam int DEF_BAUD_RATE   = 115_200;
   localparam int DEF_CLOCK_SPEED = 50_000_000;
   localparam int DEF_BAUD_WIDTH  = DEF_CLOCK_SPEED / DEF_BAUD_RATE;

   // Bit position of each state inside the one-hot state vector.
   typedef enum int unsigned {
      IDLE_BIT  = 0,
      START_BIT = 1,
      DATA_BIT  = 2,
      STOP_BIT  = 3
   } state_bit_e;

   typedef enum logic [3:0] {
      IDLE  = 4'b0001 << IDLE_BIT,
      START = 4'b0001 << START_BIT,
      DATA  = 4'b0001 << DATA_BIT,
      STOP  = 4'b0001 << STOP_BIT
   } state_e;

   // One 8N1 frame in line order: start bit, data LSB first, stop bit.
   typedef struct packed {
      logic       start;
      logic [0:7] data_lsb;
      logic       stop;
   } packet_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Purpose : bit-period cycle counter; counts while en, pulses tick when the count equals
//           term_cnt and restarts from zero on that cycle, on clr, or loads ld_val on ld.
// Latency : tick is combinational from the count register; the count updates on the next edge.
// Backpressure: none.
// Ports   : clk, rst (sync, active-high), clr, en, ld, ld_val, term_cnt in; tick out.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int WIDTH = DEF_BAUD_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             ld,
   input  logic [CNT_W-1:0] ld_val,
   input  logic [CNT_W-1:0] term_cnt,
   output logic             tick
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == term_cnt);

   // The counter never relies on natural overflow: it is cleared explicitly at the
   // terminal count so any period up to 2**CNT_W works.
   always_comb begin
      cnt_d = cnt_q;
      if (clr || tick) begin
         cnt_d = '0;
      end else if (ld) begin
         cnt_d = ld_val;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// Purpose : 8N1 UART receiver, LSB first; 2-FF synchronised rx, mid-bit sampling, framing check.
// Latency : rx_done is seen 2 + HALF_WIDTH + 9*BAUD_WIDTH + 1 cycles after the start edge.
// Backpressure: none; data must be taken within one frame time, the next frame overwrites it.
// Ports   : clk, rst (sync, active-high), rx in; data[7:0], rx_done, frame_err, busy out.
module uart_rx
   import uart_pkg::*;
#(
   parameter int BAUD_RATE   = DEF_BAUD_RATE,
   parameter int CLOCK_SPEED = DEF_CLOCK_SPEED
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       rx_done,
   output logic       frame_err,
   output logic       busy
);

   localparam int BAUD_WIDTH = int'(CLOCK_SPEED / BAUD_RATE);
   localparam int HALF_WIDTH = BAUD_WIDTH / 2;
   localparam int CNT_W      = $clog2(BAUD_WIDTH);
   localparam logic [CNT_W-1:0] BAUD_TERM = CNT_W'(BAUD_WIDTH - 1);
   localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(HALF_WIDTH - 1);

   state_e     state_q, state_d;
   logic       rx_meta_q, rx_meta_d;
   logic       rx_s_q, rx_s_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] data_q, data_d;
   logic       rx_done_q, rx_done_d;
   logic       frame_err_q, frame_err_d;
   logic       err_hold_q, err_hold_d;   // stop bit was low; waiting for the line to go idle

   logic             cnt_clr;
   logic             cnt_en;
   logic [CNT_W-1:0] term_cnt;
   logic             tick;

   assign rx_meta_d = rx;
   assign rx_s_d    = rx_meta_q;
   assign cnt_en    = (state_q != IDLE) && !err_hold_q;

   uart_baud_cnt #(
      .WIDTH (BAUD_WIDTH),
      .CNT_W (CNT_W)
   ) u_baud_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .en       (cnt_en),
      .ld       (1'b0),
      .ld_val   ({CNT_W{1'b0}}),
      .term_cnt (term_cnt),
      .tick     (tick)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      rx_done_d   = 1'b0;
      frame_err_d = 1'b0;
      err_hold_d  = err_hold_q;
      cnt_clr     = 1'b0;
      term_cnt    = BAUD_TERM;
      case (state_q)
         IDLE: begin
            if (!rx_s_q) begin
               state_d = START;
               cnt_clr = 1'b1;
            end
         end
         START: begin
            // Half a bit after the edge: a line that is high again was a glitch.
            term_cnt = HALF_TERM;
            if (tick) begin
               cnt_clr = 1'b1;
               if (!rx_s_q) begin
                  state_d = DATA;
                  idx_d   = 3'd0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (tick) begin
               shift_d[idx_q] = rx_s_q;
               if (idx_q == 3'd7) begin
                  state_d = STOP;
                  cnt_clr = 1'b1;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (err_hold_q) begin
               // Staying here through a break keeps a low line from looking like a start bit.
               if (rx_s_q) begin
                  state_d    = IDLE;
                  err_hold_d = 1'b0;
                  cnt_clr    = 1'b1;
               end
            end else if (tick) begin
               if (rx_s_q) begin
                  data_d    = shift_q;
                  rx_done_d = 1'b1;
                  state_d   = IDLE;
                  cnt_clr   = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
                  err_hold_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d    = IDLE;
            err_hold_d = 1'b0;
            cnt_clr    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         idx_q       <= 3'd0;
         shift_q     <= 8'h00;
         data_q      <= 8'h00;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
         err_hold_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rx_meta_q   <= rx_meta_d;
         rx_s_q      <= rx_s_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         rx_done_q   <= rx_done_d;
         frame_err_q <= frame_err_d;
         err_hold_q  <= err_hold_d;
      end
   end

   assign data      = data_q;
   assign rx_done   = rx_done_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Purpose : directed self-checking bench for uart_rx at 10 clocks per bit.
// Latency : expected rx_done cycle is derived from the 2-FF sync, half-bit and nine bit periods.
// Backpressure: none; received bytes are queued by a monitor and compared in order.
module tb_uart_rx;

   localparam int BW  = 10;                 // 1 MHz / 100 kbit/s
   localparam int HW  = BW / 2;
   localparam int LAT = 2 + HW + 9*BW + 1;  // 98 cycles from the start edge to rx_done

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       rx_done;
   logic       frame_err;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int done_cnt = 0;
   int ferr_cnt = 0;
   int both_cnt = 0;
   int done_cyc = 0;
   int t0 = 0;
   logic [7:0] got_q[$];

   uart_rx #(
      .BAUD_RATE   (100_000),
      .CLOCK_SPEED (1_000_000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (data),
      .rx_done   (rx_done),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
         got_q.push_back(data);
      end
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if (rx_done && frame_err) both_cnt <= both_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pop_got();
      if (got_q.size() == 0) return 32'hDEAD;
      return 32'(got_q.pop_front());
   endfunction

   task automatic drive_bits(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      t0 = cyc;
      drive_bits(1'b0, BW);
      for (int i = 0; i < 8; i++) drive_bits(b[i], BW);
      drive_bits(stop, BW);
   endtask

   task automatic idle(input int n);
      drive_bits(1'b1, n);
   endtask

   initial begin
      int d0, f0, busy_n;
      logic [9:0] bits;

      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_data",      32'(data),      32'h00);
      chk("rst_rx_done",   32'(rx_done),   32'h0);
      chk("rst_frame_err", 32'(frame_err), 32'h0);
      chk("rst_busy",      32'(busy),      32'h0);
      rst = 1'b0;
      idle(5);

      // Single good frame, including the exact rx_done cycle.
      d0 = done_cnt; f0 = ferr_cnt;
      send_frame(8'hA5, 1'b1);
      idle(2*BW);
      chk("a5_done_cnt", done_cnt - d0, 1);
      chk("a5_ferr_cnt", ferr_cnt - f0, 0);
      chk("a5_byte",     pop_got(), 32'hA5);
      chk("a5_latency",  done_cyc - t0, LAT);
      chk("a5_data_out", 32'(data), 32'hA5);

      // Back-to-back frames with a single stop bit each.
      d0 = done_cnt; f0 = ferr_cnt;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h3C, 1'b1);
      idle(2*BW);
      chk("b2b_done_cnt", done_cnt - d0, 3);
      chk("b2b_ferr_cnt", ferr_cnt - f0, 0);
      chk("b2b_byte0", pop_got(), 32'h00);
      chk("b2b_byte1", pop_got(), 32'hFF);
      chk("b2b_byte2", pop_got(), 32'h3C);

      // Low stop bit: framing error, data held, next frame still good.
      d0 = done_cnt; f0 = ferr_cnt;
      send_frame(8'h5A, 1'b0);
      idle(3*BW);
      chk("ferr_ferr_cnt", ferr_cnt - f0, 1);
      chk("ferr_done_cnt", done_cnt - d0, 0);
      chk("ferr_data_held", 32'(data), 32'h3C);
      chk("ferr_busy_idle", 32'(busy), 32'h0);
      d0 = done_cnt;
      send_frame(8'h81, 1'b1);
      idle(2*BW);
      chk("after_ferr_done_cnt", done_cnt - d0, 1);
      chk("after_ferr_byte",     pop_got(), 32'h81);

      // Short low glitch: no strobes, busy only for the half-bit check.
      d0 = done_cnt; f0 = ferr_cnt; busy_n = 0;
      for (int k = 0; k < 30; k++) begin
         rx = (k < 3) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (busy) busy_n++;
      end
      chk("glitch_busy_bounded", 32'((busy_n >= 1) && (busy_n <= 7)), 32'h1);
      chk("glitch_done_cnt", done_cnt - d0, 0);
      chk("glitch_ferr_cnt", ferr_cnt - f0, 0);
      chk("glitch_busy_end", 32'(busy), 32'h0);

      // One-cycle reset in the middle of data bit 4.
      d0 = done_cnt; f0 = ferr_cnt;
      bits = {1'b1, 8'hF0, 1'b0};
      for (int i = 0; i < 5; i++) drive_bits(bits[i], BW);
      rx = bits[5];
      repeat (HW) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_data",      32'(data),      32'h00);
      chk("midrst_rx_done",   32'(rx_done),   32'h0);
      chk("midrst_frame_err", 32'(frame_err), 32'h0);
      chk("midrst_busy",      32'(busy),      32'h0);
      idle(2*BW);
      chk("midrst_no_done", done_cnt - d0, 0);
      chk("midrst_no_ferr", ferr_cnt - f0, 0);
      send_frame(8'hC3, 1'b1);
      idle(2*BW);
      chk("c3_done_cnt", done_cnt - d0, 1);
      chk("c3_byte",     pop_got(), 32'hC3);

      // Break: one framing error, then parked in STOP until the line returns high.
      d0 = done_cnt; f0 = ferr_cnt;
      drive_bits(1'b0, 30*BW);
      chk("brk_busy_held", 32'(busy), 32'h1);
      chk("brk_ferr_cnt",  ferr_cnt - f0, 1);
      chk("brk_done_cnt",  done_cnt - d0, 0);
      idle(BW);
      chk("brk_busy_release", 32'(busy), 32'h0);
      chk("brk_ferr_once",    ferr_cnt - f0, 1);
      chk("brk_data_held",    32'(data), 32'hC3);

      chk("never_both",   both_cnt, 0);
      chk("no_extra_rx",  got_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
